// File: rtl/mmul_parallel_tcdm_slice_pkg.sv
// Shared types and helpers for the parallel TCDM register slice.
//   slot_state_e  : per-port request slot state (EMPTY / FULL)
//   tcdm_req_t    : one buffered request (add/wen/be/data) at default widths
//   max_out_valid : elaboration-time sanity check for the outstanding limit
package mmul_parallel_slice_package;

    localparam int unsigned SLICE_ADDR_W  = 32;
    localparam int unsigned SLICE_DATA_W  = 32;
    localparam int unsigned SLICE_BE_W    = SLICE_DATA_W / 8;
    localparam int unsigned SLICE_MAX_OUT = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [SLICE_ADDR_W-1:0] add;
        logic                    wen;
        logic [SLICE_BE_W-1:0]   be;
        logic [SLICE_DATA_W-1:0] data;
    } tcdm_req_t;

    // A limit of zero would deadlock the port: nothing could ever be accepted.
    function automatic bit max_out_valid(input int unsigned max_out);
        return max_out >= 1;
    endfunction

endpackage

// File: rtl/mmul_parallel_tcdm_slice_port.sv
// One port of the TCDM register slice.
//   acc_*   : accelerator-side request in, grant out, registered response out
//   tcdm_*  : cluster-side registered request out, grant/response in
//   busy_o  : slot FULL or transactions still outstanding
//   err_o   : sticky, a response arrived with nothing outstanding
module mmul_parallel_tcdm_slice_port
    import mmul_parallel_slice_package::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BE_W    = DATA_W / 8,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              acc_req_i,
    output logic              acc_gnt_o,
    input  logic [ADDR_W-1:0] acc_add_i,
    input  logic              acc_wen_i,
    input  logic [BE_W-1:0]   acc_be_i,
    input  logic [DATA_W-1:0] acc_data_i,
    output logic [DATA_W-1:0] acc_r_data_o,
    output logic              acc_r_valid_o,
    output logic              tcdm_req_o,
    output logic [ADDR_W-1:0] tcdm_add_o,
    output logic              tcdm_wen_o,
    output logic [BE_W-1:0]   tcdm_be_o,
    output logic [DATA_W-1:0] tcdm_data_o,
    input  logic              tcdm_gnt_i,
    input  logic [DATA_W-1:0] tcdm_r_data_i,
    input  logic              tcdm_r_valid_i,
    output logic              busy_o,
    output logic              err_o
);

    slot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] add_q, add_d;
    logic              wen_q, wen_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              r_valid_q, r_valid_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;

    logic accept;
    logic cnt_ok;
    logic cnt_zero;

    // The limit uses the registered count only; a response in the same cycle
    // frees a credit for the next cycle, keeping acc_gnt off the r_valid path.
    assign cnt_ok    = cnt_q < CNT_W'(MAX_OUT);
    assign cnt_zero  = (cnt_q == '0);
    assign acc_gnt_o = ((state_q == EMPTY) || tcdm_gnt_i) && cnt_ok;
    assign accept    = acc_req_i && acc_gnt_o;

    always_comb begin
        state_d   = state_q;
        add_d     = add_q;
        wen_d     = wen_q;
        be_d      = be_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        r_valid_d = tcdm_r_valid_i;
        r_data_d  = r_data_q;

        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (tcdm_gnt_i && !accept) state_d = EMPTY;
        endcase

        // Reload on accept; when the slot drains, zero it so the cluster
        // side shows an all-zero request while idle.
        if (accept) begin
            add_d  = acc_add_i;
            wen_d  = acc_wen_i;
            be_d   = acc_be_i;
            data_d = acc_data_i;
        end else if ((state_q == FULL) && tcdm_gnt_i) begin
            add_d  = '0;
            wen_d  = 1'b0;
            be_d   = '0;
            data_d = '0;
        end

        // A response with nothing outstanding cannot retire anything: it does
        // not cancel a same-cycle accept and only raises the error flag.
        if (tcdm_r_valid_i && cnt_zero) begin
            err_d = 1'b1;
            if (accept) cnt_d = cnt_q + CNT_W'(1);
        end else if (accept && !tcdm_r_valid_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && tcdm_r_valid_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (tcdm_r_valid_i) r_data_d = tcdm_r_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= EMPTY;
            add_q     <= '0;
            wen_q     <= 1'b0;
            be_q      <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            add_q     <= add_d;
            wen_q     <= wen_d;
            be_q      <= be_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
        end
    end

    assign tcdm_req_o    = (state_q == FULL);
    assign tcdm_add_o    = add_q;
    assign tcdm_wen_o    = wen_q;
    assign tcdm_be_o     = be_q;
    assign tcdm_data_o   = data_q;
    assign acc_r_valid_o = r_valid_q;
    assign acc_r_data_o  = r_data_q;
    assign busy_o        = (state_q == FULL) || !cnt_zero;
    assign err_o         = err_q;

endmodule

// File: rtl/mmul_parallel_tcdm_slice.sv
// Register slice between the accelerator's MP flattened TCDM master ports and
// the cluster interconnect. Every port gets a one-entry request register, a
// registered response and an outstanding-transaction limiter.
//   acc_*  : accelerator side (request in, grant out, response out)
//   tcdm_* : cluster side (request out, grant in, response in)
//   busy_o : per-port activity, idle_o = no port busy
//   err_o  : per-port sticky spurious-response flag
module mmul_parallel_tcdm_slice
    import mmul_parallel_slice_package::*;
#(
    parameter int unsigned MP      = 3,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BE_W    = DATA_W / 8,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [MP-1:0]                acc_req,
    output logic [MP-1:0]                acc_gnt,
    input  logic [MP-1:0][ADDR_W-1:0]    acc_add,
    input  logic [MP-1:0]                acc_wen,
    input  logic [MP-1:0][BE_W-1:0]      acc_be,
    input  logic [MP-1:0][DATA_W-1:0]    acc_data,
    output logic [MP-1:0][DATA_W-1:0]    acc_r_data,
    output logic [MP-1:0]                acc_r_valid,
    output logic [MP-1:0]                tcdm_req,
    output logic [MP-1:0][ADDR_W-1:0]    tcdm_add,
    output logic [MP-1:0]                tcdm_wen,
    output logic [MP-1:0][BE_W-1:0]      tcdm_be,
    output logic [MP-1:0][DATA_W-1:0]    tcdm_data,
    input  logic [MP-1:0]                tcdm_gnt,
    input  logic [MP-1:0][DATA_W-1:0]    tcdm_r_data,
    input  logic [MP-1:0]                tcdm_r_valid,
    output logic [MP-1:0]                busy_o,
    output logic                         idle_o,
    output logic [MP-1:0]                err_o
);

    if (!max_out_valid(MAX_OUT) || ((DATA_W % 8) != 0)) begin : g_param_err
        $error("mmul_parallel_tcdm_slice: MAX_OUT must be >= 1 and DATA_W a multiple of 8");
    end

    for (genvar i = 0; i < MP; i++) begin : g_port
        mmul_parallel_tcdm_slice_port #(
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W),
            .BE_W    (BE_W),
            .MAX_OUT (MAX_OUT),
            .CNT_W   (CNT_W)
        ) u_port (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .acc_req_i      (acc_req[i]),
            .acc_gnt_o      (acc_gnt[i]),
            .acc_add_i      (acc_add[i]),
            .acc_wen_i      (acc_wen[i]),
            .acc_be_i       (acc_be[i]),
            .acc_data_i     (acc_data[i]),
            .acc_r_data_o   (acc_r_data[i]),
            .acc_r_valid_o  (acc_r_valid[i]),
            .tcdm_req_o     (tcdm_req[i]),
            .tcdm_add_o     (tcdm_add[i]),
            .tcdm_wen_o     (tcdm_wen[i]),
            .tcdm_be_o      (tcdm_be[i]),
            .tcdm_data_o    (tcdm_data[i]),
            .tcdm_gnt_i     (tcdm_gnt[i]),
            .tcdm_r_data_i  (tcdm_r_data[i]),
            .tcdm_r_valid_i (tcdm_r_valid[i]),
            .busy_o         (busy_o[i]),
            .err_o          (err_o[i])
        );
    end

    assign idle_o = ~|busy_o;

endmodule

// File: tb/tb_mmul_parallel_tcdm_slice.sv
// Scoreboard bench for mmul_parallel_tcdm_slice (default parameters).
// A behavioural cluster records granted requests and answers one cycle after
// the grant: reads return add ^ 32'hDEADBFEF, writes echo the write data.
module tb_mmul_parallel_tcdm_slice;

    localparam int MP = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [MP-1:0]        acc_req, acc_gnt, acc_wen, acc_r_valid;
    logic [MP-1:0][31:0]  acc_add, acc_data, acc_r_data;
    logic [MP-1:0][3:0]   acc_be;
    logic [MP-1:0]        tcdm_req, tcdm_wen, tcdm_gnt, tcdm_r_valid;
    logic [MP-1:0][31:0]  tcdm_add, tcdm_data, tcdm_r_data;
    logic [MP-1:0][3:0]   tcdm_be;
    logic [MP-1:0]        busy_o, err_o;
    logic                 idle_o;

    mmul_parallel_tcdm_slice dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .acc_req      (acc_req),
        .acc_gnt      (acc_gnt),
        .acc_add      (acc_add),
        .acc_wen      (acc_wen),
        .acc_be       (acc_be),
        .acc_data     (acc_data),
        .acc_r_data   (acc_r_data),
        .acc_r_valid  (acc_r_valid),
        .tcdm_req     (tcdm_req),
        .tcdm_add     (tcdm_add),
        .tcdm_wen     (tcdm_wen),
        .tcdm_be      (tcdm_be),
        .tcdm_data    (tcdm_data),
        .tcdm_gnt     (tcdm_gnt),
        .tcdm_r_data  (tcdm_r_data),
        .tcdm_r_valid (tcdm_r_valid),
        .busy_o       (busy_o),
        .idle_o       (idle_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          port;
        logic [31:0] data;
    } sb_t;

    sb_t         sbq[$];
    int          nchk = 0;
    int          nerr = 0;
    logic [31:0] cl_mem [MP][64];
    int          cl_wr [MP];
    int          cl_rd [MP];
    int          release_n [MP];
    int          rel_used [MP];
    int          spur_n [MP];
    int          spur_used [MP];
    logic [MP-1:0] resp_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic send(input int p, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [31:0] e, output int nw);
        bit ok;
        ok = 1'b0;
        nw = 0;
        acc_req[p]  = 1'b1;
        acc_add[p]  = a;
        acc_wen[p]  = w;
        acc_be[p]   = 4'hF;
        acc_data[p] = d;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk_i);
            nw++;
            if (acc_gnt[p]) begin
                ok = 1'b1;
                sbq.push_back('{p, e});
            end
            @(posedge clk_i); #1;
        end
        acc_req[p] = 1'b0;
        if (!ok) begin
            nchk++;
            nerr++;
            $display("FAIL send_timeout: port %0d got no grant, required grant within 50 cycles", p);
        end
    endtask

    // Ends at a negedge once every expected response has been seen.
    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk_i);
            if (idle_o && (sbq.size() == 0) && (acc_r_valid == '0)) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        int nw;
        int nacc;
        int ncyc;
        rst_ni      = 1'b0;
        acc_req     = '0;
        acc_add     = '0;
        acc_wen     = '0;
        acc_be      = '0;
        acc_data    = '0;
        tcdm_gnt    = '0;
        tcdm_r_valid = '0;
        tcdm_r_data = '0;
        resp_hold   = '0;
        for (int p = 0; p < MP; p++) begin
            cl_wr[p] = 0; cl_rd[p] = 0; release_n[p] = 0;
            rel_used[p] = 0; spur_n[p] = 0; spur_used[p] = 0;
        end

        fork
            // monitor: every registered response is matched against the scoreboard
            forever begin
                @(negedge clk_i);
                for (int p = 0; p < MP; p++) begin
                    if (acc_r_valid[p]) begin
                        if (sbq.size() == 0) begin
                            nchk++;
                            nerr++;
                            $display("FAIL resp_unexpected: port %0d got %h, required no response", p, acc_r_data[p]);
                        end else begin
                            sb_t e;
                            e = sbq.pop_front();
                            chk("resp_port", 32'(p), 32'(e.port));
                            chk("resp_data", acc_r_data[p], e.data);
                        end
                    end
                end
            end
            // cluster request side: record handshakes that complete at the next edge
            forever begin
                @(negedge clk_i);
                if (rst_ni) begin
                    for (int p = 0; p < MP; p++) begin
                        if (tcdm_req[p] && tcdm_gnt[p]) begin
                            cl_mem[p][cl_wr[p] % 64] = tcdm_wen[p] ? (tcdm_add[p] ^ 32'hDEADBFEF) : tcdm_data[p];
                            cl_wr[p]++;
                        end
                    end
                end
            end
            // cluster response side: answer one cycle after the grant
            forever begin
                @(posedge clk_i); #1;
                for (int p = 0; p < MP; p++) begin
                    tcdm_r_valid[p] = 1'b0;
                    if (!rst_ni) begin
                        cl_rd[p] = cl_wr[p];
                    end else if (spur_used[p] != spur_n[p]) begin
                        spur_used[p]++;
                        tcdm_r_valid[p] = 1'b1;
                        tcdm_r_data[p]  = 32'h5151_5151;
                    end else if ((cl_rd[p] != cl_wr[p]) && (!resp_hold[p] || (rel_used[p] != release_n[p]))) begin
                        tcdm_r_valid[p] = 1'b1;
                        tcdm_r_data[p]  = cl_mem[p][cl_rd[p] % 64];
                        cl_rd[p]++;
                        if (resp_hold[p]) rel_used[p]++;
                    end
                end
            end
        join_none

        // reset values
        repeat (2) @(negedge clk_i);
        chk("rst_tcdm_req", 32'(tcdm_req), 32'd0);
        chk("rst_tcdm_add", tcdm_add[0] | tcdm_add[1] | tcdm_add[2], 32'd0);
        chk("rst_acc_r_valid", 32'(acc_r_valid), 32'd0);
        chk("rst_acc_r_data", acc_r_data[0] | acc_r_data[1] | acc_r_data[2], 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_idle", 32'(idle_o), 32'd1);
        chk("rst_err", 32'(err_o), 32'd0);
        @(posedge clk_i); #1;
        rst_ni   = 1'b1;
        tcdm_gnt = '1;
        @(posedge clk_i); #1;

        // single read, zero-wait cluster
        send(0, 32'h100, 1'b1, 32'h0, 32'hDEADBEEF, nw);
        @(negedge clk_i);
        chk("rd_tcdm_req", 32'(tcdm_req[0]), 32'd1);
        chk("rd_tcdm_add", tcdm_add[0], 32'h100);
        chk("rd_tcdm_wen", 32'(tcdm_wen[0]), 32'd1);
        wait_drain("rd_drain");
        chk("rd_idle", 32'(idle_o), 32'd1);
        @(posedge clk_i); #1;

        // grant stall on port 0
        tcdm_gnt[0] = 1'b0;
        send(0, 32'h200, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, nw);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall_add", tcdm_add[0], 32'h200);
            chk("stall_data", tcdm_data[0], 32'hCAFEF00D);
            chk("stall_gnt", 32'(acc_gnt[0]), 32'd0);
        end
        chk("stall_req", 32'(tcdm_req[0]), 32'd1);
        chk("stall_be", 32'(tcdm_be[0]), 32'hF);
        @(posedge clk_i); #1;
        tcdm_gnt[0] = 1'b1;
        #1;
        chk("stall_gnt_release", 32'(acc_gnt[0]), 32'd1);
        wait_drain("stall_drain");
        @(posedge clk_i); #1;

        // outstanding limit: grants continue, responses withheld
        resp_hold[0] = 1'b1;
        acc_req[0]   = 1'b1;
        acc_wen[0]   = 1'b0;
        acc_be[0]    = 4'hF;
        acc_add[0]   = 32'h300;
        acc_data[0]  = 32'h1111_0000;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (acc_gnt[0]) begin
                sbq.push_back('{0, acc_data[0]});
                nacc++;
            end
            @(posedge clk_i); #1;
            acc_data[0] = 32'h1111_0000 + 32'(nacc);
            acc_add[0]  = 32'h300 + 32'(4 * nacc);
        end
        chk("out_accepts", 32'(nacc), 32'd4);
        @(negedge clk_i);
        chk("out_gnt_full", 32'(acc_gnt[0]), 32'd0);
        release_n[0] = 1;
        @(negedge clk_i);
        chk("out_gnt_same_cycle", 32'(acc_gnt[0]), 32'd0);
        @(negedge clk_i);
        chk("out_gnt_after_resp", 32'(acc_gnt[0]), 32'd1);
        if (acc_gnt[0]) sbq.push_back('{0, acc_data[0]});
        @(negedge clk_i);
        chk("out_gnt_refull", 32'(acc_gnt[0]), 32'd0);
        @(posedge clk_i); #1;
        acc_req[0]   = 1'b0;
        resp_hold[0] = 1'b0;
        wait_drain("out_drain");
        @(posedge clk_i); #1;

        // streaming: 16 back-to-back reads
        ncyc = 0;
        for (int i = 0; i < 16; i++) begin
            send(0, 32'h1000 + 32'(4 * i), 1'b1, 32'h0, (32'h1000 + 32'(4 * i)) ^ 32'hDEADBFEF, nw);
            ncyc += nw;
        end
        chk("stream_cycles", 32'(ncyc), 32'd16);
        wait_drain("stream_drain");

        // spurious response on port 2
        @(negedge clk_i);
        spur_n[2] = 1;
        sbq.push_back('{2, 32'h5151_5151});
        repeat (2) @(negedge clk_i);
        chk("spur_err", 32'(err_o), 32'b100);
        chk("spur_busy", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk_i);
        chk("spur_err_sticky", 32'(err_o), 32'b100);
        chk("spur_idle", 32'(idle_o), 32'd1);
        wait_drain("spur_drain");
        @(posedge clk_i); #1;

        // reset with port 1 FULL and three outstanding
        resp_hold[1] = 1'b1;
        for (int i = 0; i < 3; i++)
            send(1, 32'h400 + 32'(4 * i), 1'b0, 32'hA0 + 32'(i), 32'hA0 + 32'(i), nw);
        tcdm_gnt[1] = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_req", 32'(tcdm_req[1]), 32'd1);
        chk("pre_rst_gnt", 32'(acc_gnt[1]), 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_tcdm_req", 32'(tcdm_req), 32'd0);
        chk("arst_tcdm_add", tcdm_add[1], 32'd0);
        chk("arst_tcdm_data", tcdm_data[1], 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_idle", 32'(idle_o), 32'd1);
        chk("arst_err", 32'(err_o), 32'd0);
        chk("arst_acc_gnt", 32'(acc_gnt), 32'b111);
        sbq.delete();
        resp_hold[1] = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni   = 1'b1;
        tcdm_gnt = '1;
        @(posedge clk_i); #1;
        send(1, 32'h340, 1'b1, 32'h0, 32'hDEADBCAF, nw);
        wait_drain("post_rst_drain");
        chk("post_rst_err", 32'(err_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mmul_parallel_tcdm_slice.md
# mmul_parallel_tcdm_slice

Parametrised TCDM register slice placed between the accelerator's flattened TCDM master ports and the cluster interconnect. It breaks the combinational request and response paths of all `MP` ports. Per port it provides:
- a one-entry request register,
- a registered response,
- an outstanding-transaction limiter.

It generalises the previous bare wrapper bindings, adding configurable data width, a per-port outstanding limit, busy/idle status and protocol-error detection.

## Interface
Parameters:
- `MP`, 3, number of TCDM ports.
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; must be a multiple of 8.
- `BE_W`, `DATA_W/8`, byte-enable width (derived).
- `MAX_OUT`, 4, maximum accepted-but-unanswered transactions per port; minimum 1.
- `CNT_W`, `$clog2(MAX_OUT+1)`, outstanding counter width (derived).

Ports:
- `clk_i`  in  1  clock. One clock domain; all state on the rising edge.
- `rst_ni`  in  1  reset, asynchronous assertion, active-low.
- `acc_req`  in  [MP-1:0]  accelerator-side request.
- `acc_gnt`  out  [MP-1:0]  accelerator-side grant.
- `acc_add`  in  [MP-1:0][ADDR_W-1:0]  request address.
- `acc_wen`  in  [MP-1:0]  1 = read, 0 = write.
- `acc_be`  in  [MP-1:0][BE_W-1:0]  byte enables.
- `acc_data`  in  [MP-1:0][DATA_W-1:0]  write data.
- `acc_r_data`  out  [MP-1:0][DATA_W-1:0]  response data.
- `acc_r_valid`  out  [MP-1:0]  response valid.
- `tcdm_req`, `tcdm_add`, `tcdm_wen`, `tcdm_be`, `tcdm_data`  out  as the `acc_*` counterparts  cluster-side request.
- `tcdm_gnt`  in  [MP-1:0]  cluster-side grant.
- `tcdm_r_data`  in  [MP-1:0][DATA_W-1:0]  cluster-side response data.
- `tcdm_r_valid`  in  [MP-1:0]  cluster-side response valid.
- `busy_o`  out  [MP-1:0]  port has a buffered request or a nonzero outstanding count.
- `idle_o`  out  1  `~|busy_o`.
- `err_o`  out  [MP-1:0]  sticky flag: a response arrived while the outstanding count was 0.

## Operation
- Ports are fully independent. Per port there is a slot state machine with states EMPTY and FULL, and an outstanding counter `cnt`.
- Accept condition: `acc_gnt = (EMPTY | (FULL & tcdm_gnt)) & (cnt < MAX_OUT)`.
  - The accept is `acc_req & acc_gnt`.
  - The check uses the registered `cnt`. A response arriving in the same cycle does not relax the limit.
- Slot state transitions:
  - EMPTY + accept → FULL. The slot captures `add/wen/be/data`.
  - FULL + `tcdm_gnt` + accept → FULL, slot reloaded. Back-to-back throughput is 1 transaction per cycle.
  - FULL + `tcdm_gnt` + no accept → EMPTY.
  - FULL + no `tcdm_gnt` → FULL. The slot contents are held stable.
- Cluster-side request: `tcdm_req = FULL`; `tcdm_add/wen/be/data` are driven from the slot. These are zero while EMPTY.
- Counter update: `cnt` increments on accept and decrements on `tcdm_r_valid`. If both happen in the same cycle, `cnt` is unchanged.
- Counter saturation:
  - `cnt` never exceeds `MAX_OUT`; this is guaranteed by the accept condition.
  - A `tcdm_r_valid` while `cnt==0` leaves `cnt` at 0 and sets `err_o` until reset.
- Response path: `acc_r_valid <= tcdm_r_valid` and `acc_r_data <= tcdm_r_data`, one register stage, no backpressure.
  - `acc_r_data` updates only when `tcdm_r_valid=1`; otherwise it holds its last value.
- The cluster returns exactly one in-order `r_valid` per granted request, for both reads and writes. The slice does not reorder.

## Timing
- Reset values: slots EMPTY, `cnt=0`, `err_o=0`, `tcdm_req=0`, `tcdm_add/wen/be/data=0`, `acc_r_valid=0`, `acc_r_data=0`, `busy_o=0`, `idle_o=1`.
- Reset assertion mid-transaction drops the slot and counters immediately, without waiting for a clock edge. In-flight responses arriving after reset release raise `err_o`.
- Request latency: accept at edge t → `tcdm_req=1` at cycle t+1.
- End-to-end latency with a zero-wait cluster (gnt at t+1, `r_valid` at t+2) → `acc_r_valid` at t+3.
- `acc_gnt` depends combinationally on `tcdm_gnt` and registered state only. It must not depend on `acc_req`.
- `tcdm_*` request outputs and `acc_r_*` outputs are purely registered.

## Structure
- A shared package `mmul_parallel_slice_package` holds:
  - `slot_state_e` (EMPTY, FULL),
  - the `tcdm_req_t` struct (`add/wen/be/data`, parametrised via localparams matching the defaults),
  - an `MAX_OUT` sanity check.
- Sub-module `mmul_parallel_tcdm_slice_port`: one port (slot FSM, counter, response register). The top level instantiates it `MP` times in a generate loop and ORs `busy_o` into `idle_o`.

## Test plan
- **Single read, zero-wait:** port 0 read at `add=0x100` with `tcdm_gnt` held 1, cluster returning `0xDEADBEEF` one cycle after grant.
  - `tcdm_req` at t+1.
  - `acc_r_valid` with `0xDEADBEEF` at t+3.
  - `idle_o=1` at t+4.
- **Grant stall:** `tcdm_gnt=0` for 5 cycles.
  - `tcdm_add/data` stay stable.
  - `acc_gnt=0` while FULL.
  - On the first cycle `tcdm_gnt=1`, `acc_gnt=1`.
- **Outstanding limit:** `MAX_OUT=4`, continuous writes, cluster grants but withholds `r_valid`.
  - Exactly 4 accepts, then `acc_gnt=0`.
  - After one `r_valid`, the next cycle allows one accept.
- **Streaming throughput:** 16 back-to-back requests, zero-wait cluster.
  - 16 accepts in 16 consecutive cycles.
  - 16 in-order responses.
  - `cnt` peaks at 2.
- **Spurious response:** `tcdm_r_valid` on port 2 with no traffic.
  - `err_o[2]=1` and stays 1.
  - Other ports are unaffected.
  - `cnt[2]` remains 0.
- **Reset mid-operation:** assert `rst_ni` with port 1 FULL and `cnt=3`.
  - All outputs return to reset values asynchronously.
  - After release, a new read completes normally.
